// File: rtl/pong_pkg.sv
// Shared types and constants for the Pong match controller: FSM state codes,
// winner codes, serve directions and default match parameters.
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        WIN_NONE = 2'd0,
        WIN_P1   = 2'd1,
        WIN_P2   = 2'd2
    } winner_t;

    localparam logic DIR_P1 = 1'b0;
    localparam logic DIR_P2 = 1'b1;

    localparam int DEF_WIN_SCORE    = 7;
    localparam int DEF_PAUSE_FRAMES = 60;

    // Pause counter must hold 0..frames; keep at least one bit when frames is 0.
    function automatic int cnt_width(input int frames);
        return (frames < 1) ? 1 : $clog2(frames + 1);
    endfunction

endpackage

// File: rtl/pong_match_ctrl_rise_edge_detect.sv
// Registered rising-edge detector; RESET_LEVEL sets the history flop's reset
// value so a level already high at reset release is not seen as an edge.
module rise_edge_detect #(
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic clk_100MHz,
    input  logic reset,
    input  logic in,
    output logic pulse
);

    logic prev;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            prev  <= RESET_LEVEL;
            pulse <= 1'b0;
        end else begin
            prev  <= in;
            pulse <= in & ~prev;
        end
    end

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: runs/freezes/re-centres the ball, keeps scores, declares
// a winner. Define PONG_AUTO_SERVE_EN to auto-serve after PAUSE_FRAMES ticks in SERVE.
module pong_match_ctrl
    import pong_pkg::*;
#(
    parameter int WIN_SCORE    = DEF_WIN_SCORE,
    parameter int PAUSE_FRAMES = DEF_PAUSE_FRAMES,
    parameter int SCORE_W      = 4
) (
    input  logic               clk_100MHz,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               serve,
    input  logic               miss1,
    input  logic               miss2,
    output logic               ball_run,
    output logic               ball_reset,
    output logic               serve_dir,
    output logic [SCORE_W-1:0] score1,
    output logic [SCORE_W-1:0] score2,
    output logic [2:0]         state,
    output logic [1:0]         winner
);

    localparam int CNT_W = cnt_width(PAUSE_FRAMES);

    state_t             state_q, state_nxt;
    winner_t            win_q, win_nxt;
    logic [CNT_W-1:0]   cnt_q, cnt_nxt;
    logic [SCORE_W-1:0] s1_nxt, s2_nxt;
    logic               run_nxt, brst_nxt, dir_nxt;
    logic               serve_evt;
    logic               last_tick;
    logic               p1_won, p2_won;

    rise_edge_detect #(.RESET_LEVEL(1'b1)) u_serve_edge (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .in         (serve),
        .pulse      (serve_evt)
    );

    assign last_tick = (PAUSE_FRAMES == 0) || (cnt_q == CNT_W'(PAUSE_FRAMES - 1));
    assign p1_won    = (score1 == SCORE_W'(WIN_SCORE));
    assign p2_won    = (score2 == SCORE_W'(WIN_SCORE));

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state_q;
        win_nxt   = win_q;
        cnt_nxt   = cnt_q;
        s1_nxt    = score1;
        s2_nxt    = score2;
        run_nxt   = ball_run;
        brst_nxt  = 1'b0;
        dir_nxt   = serve_dir;

        case (state_q)
            ST_IDLE: begin
                run_nxt = 1'b0;
                if (serve_evt) begin
                    s1_nxt    = '0;
                    s2_nxt    = '0;
                    cnt_nxt   = '0;
                    brst_nxt  = 1'b1;
                    state_nxt = ST_SERVE;
                end
            end

            ST_SERVE: begin
                run_nxt = 1'b0;
                if (serve_evt) begin
                    run_nxt   = 1'b1;
                    state_nxt = ST_PLAY;
                end
`ifdef PONG_AUTO_SERVE_EN
                else if (frame_tick) begin
                    cnt_nxt = last_tick ? CNT_W'(PAUSE_FRAMES) : cnt_q + CNT_W'(1);
                    if (last_tick) begin
                        run_nxt   = 1'b1;
                        state_nxt = ST_PLAY;
                    end
                end
`else
`endif
            end

            ST_PLAY: begin
                run_nxt = 1'b1;
                if (miss1 || miss2) begin
                    run_nxt   = 1'b0;
                    cnt_nxt   = '0;
                    state_nxt = ST_POINT;
                    if (miss1 && miss2) begin
                        dir_nxt = ~serve_dir;
                    end else if (miss1) begin
                        s2_nxt  = score2 + SCORE_W'(1);
                        dir_nxt = DIR_P1;
                    end else begin
                        s1_nxt  = score1 + SCORE_W'(1);
                        dir_nxt = DIR_P2;
                    end
                end
            end

            ST_POINT: begin
                run_nxt = 1'b0;
                if (frame_tick) begin
                    cnt_nxt = last_tick ? CNT_W'(PAUSE_FRAMES) : cnt_q + CNT_W'(1);
                    if (last_tick) begin
                        if (p1_won) begin
                            win_nxt   = WIN_P1;
                            state_nxt = ST_OVER;
                        end else if (p2_won) begin
                            win_nxt   = WIN_P2;
                            state_nxt = ST_OVER;
                        end else begin
                            brst_nxt  = 1'b1;
                            cnt_nxt   = '0;
                            state_nxt = ST_SERVE;
                        end
                    end
                end
            end

            ST_OVER: begin
                run_nxt = 1'b0;
                if (serve_evt) begin
                    s1_nxt    = '0;
                    s2_nxt    = '0;
                    win_nxt   = WIN_NONE;
                    dir_nxt   = DIR_P1;
                    cnt_nxt   = '0;
                    brst_nxt  = 1'b1;
                    state_nxt = ST_SERVE;
                end
            end

            default: begin
                run_nxt   = 1'b0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            win_q      <= WIN_NONE;
            cnt_q      <= '0;
            score1     <= '0;
            score2     <= '0;
            ball_run   <= 1'b0;
            ball_reset <= 1'b0;
            serve_dir  <= DIR_P1;
        end else begin
            state_q    <= state_nxt;
            win_q      <= win_nxt;
            cnt_q      <= cnt_nxt;
            score1     <= s1_nxt;
            score2     <= s2_nxt;
            ball_run   <= run_nxt;
            ball_reset <= brst_nxt;
            serve_dir  <= dir_nxt;
        end
    end

    assign state  = state_q;
    assign winner = win_q;

endmodule
